// File: rtl/jogador_pkg.sv
// jogador_pkg: shared states, default timing constants and LED helpers for the autonomous memory-game player
package jogador_pkg;
  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    OBSERVA   = 4'd1,
    LED_ATIVO = 4'd2,
    PRESSIONA = 4'd3,
    SOLTA     = 4'd4,
    FIM       = 4'd5
  } estado_t;
  localparam int DEPTH_PADRAO   = 16;
  localparam int PRESS_PADRAO   = 8;
  localparam int RELEASE_PADRAO = 8;
  localparam int IDLE_PADRAO    = 64;
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction
  function automatic logic [3:0] rotl4(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction
endpackage

// File: rtl/registro_sequencia.sv
// registro_sequencia: recorded step memory; the saturating count doubles as the write pointer
module registro_sequencia #(
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          escreve_i,
  input  logic [3:0]    dado_i,
  input  logic          avanca_i,
  input  logic          limpa_i,
  output logic [CW-1:0] contagem_o,
  output logic [AW-1:0] rd_ptr_o,
  output logic [3:0]    dado_rd_o
);
  logic [3:0] mem_q [DEPTH];
  logic [CW-1:0] cont_q;
  logic [AW-1:0] rd_q, rd_d;
  logic grava;
  assign grava = escreve_i && (cont_q != CW'(DEPTH));
  assign rd_d = limpa_i ? '0 : avanca_i ? rd_q + AW'(1) : rd_q;
  // read at the next pointer so a press can be loaded on the same edge the pointer moves
  assign dado_rd_o = mem_q[rd_d];
  assign contagem_o = cont_q;
  assign rd_ptr_o = rd_q;
  always_ff @(posedge clk_i)
    if (grava) mem_q[cont_q[AW-1:0]] <= dado_i;
  always_ff @(posedge clk_i) begin
    if (rst_i || limpa_i) cont_q <= '0;
    else if (grava) cont_q <= cont_q + CW'(1);
    rd_q <= rst_i ? '0 : rd_d;
  end
endmodule

// File: rtl/jogador_automatico.sv
// jogador_automatico: watches the game's LED sequence and replays it as timed button presses
// JOGADOR_INJETA_ERRO_EN adds injeta_erro, which corrupts the final press of a round
module jogador_automatico import jogador_pkg::*; #(
  parameter int DEPTH          = DEPTH_PADRAO,
  parameter int PRESS_CYCLES   = PRESS_PADRAO,
  parameter int RELEASE_CYCLES = RELEASE_PADRAO,
  parameter int IDLE_CYCLES    = IDLE_PADRAO,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          habilita,
  input  logic [3:0]    leds,
  input  logic          pronto,
`ifdef JOGADOR_INJETA_ERRO_EN
  input  logic          injeta_erro,
`endif
  output logic [3:0]    botoes,
  output logic          jogando,
  output logic [CW-1:0] capturados,
  output logic          erro_captura,
  output logic [3:0]    db_estado
);
  localparam int TMAX = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  estado_t estado_q, estado_d;
  logic [TW-1:0] tempo_q, tempo_d;
  logic [IW-1:0] ocioso_q, ocioso_d, ocioso_sat;
  logic [3:0] botoes_q, botoes_d, leds_ant_q, dado_rd, dado_tx;
  logic erro_q, erro_d, jogando_q;
  logic escreve, avanca, limpa, cheio, ultimo;
  logic [CW-1:0] contagem;
  logic [AW-1:0] rd_ptr;
  registro_sequencia #(.DEPTH(DEPTH)) u_reg (
    .clk_i(clock),
    .rst_i(reset),
    .escreve_i(escreve),
    .dado_i(leds),
    .avanca_i(avanca),
    .limpa_i(limpa),
    .contagem_o(contagem),
    .rd_ptr_o(rd_ptr),
    .dado_rd_o(dado_rd)
  );
  assign cheio = contagem == CW'(DEPTH);
  assign ultimo = CW'(rd_ptr) + CW'(1) == contagem;
  assign ocioso_sat = (ocioso_q == IW'(IDLE_CYCLES)) ? ocioso_q : ocioso_q + IW'(1);
`ifdef JOGADOR_INJETA_ERRO_EN
  logic ultimo_prox;
  assign ultimo_prox = (estado_q == OBSERVA) ? (contagem == CW'(1)) : (CW'(rd_ptr) + CW'(2) == contagem);
  assign dado_tx = (injeta_erro && ultimo_prox) ? rotl4(dado_rd) : dado_rd;
`else
  assign dado_tx = dado_rd;
`endif
  always_comb begin
    estado_d = estado_q;
    tempo_d = tempo_q;
    ocioso_d = ocioso_q;
    botoes_d = botoes_q;
    erro_d = (estado_q == INICIAL) ? 1'b0 : erro_q;
    escreve = 1'b0;
    avanca = 1'b0;
    limpa = 1'b0;
    if (!habilita) begin
      estado_d = INICIAL;
      botoes_d = '0;
      tempo_d = '0;
      ocioso_d = '0;
      limpa = 1'b1;
    end else if (pronto && estado_q != INICIAL) begin
      estado_d = FIM;
      botoes_d = '0;
    end else begin
      case (estado_q)
        INICIAL: estado_d = OBSERVA;
        OBSERVA:
          if (leds == 4'd0) begin
            if (contagem != '0) begin
              ocioso_d = ocioso_sat;
              if (ocioso_sat == IW'(IDLE_CYCLES)) begin
                estado_d = PRESSIONA;
                botoes_d = dado_tx;
                tempo_d = '0;
              end
            end
          end else if (is_onehot4(leds)) begin
            escreve = 1'b1;
            erro_d = erro_d | cheio;
            estado_d = LED_ATIVO;
            ocioso_d = '0;
          end else begin
            erro_d = 1'b1;
            ocioso_d = '0;
          end
        LED_ATIVO:
          // the dark sample that ends the LED-on period is the first idle cycle
          if (leds == 4'd0) begin
            estado_d = OBSERVA;
            ocioso_d = IW'(1);
          end else if (!is_onehot4(leds)) erro_d = 1'b1;
          else if (leds != leds_ant_q) begin
            escreve = 1'b1;
            erro_d = erro_d | cheio;
          end
        PRESSIONA:
          if (tempo_q == TW'(PRESS_CYCLES - 1)) begin
            estado_d = SOLTA;
            botoes_d = '0;
            tempo_d = '0;
          end else tempo_d = tempo_q + TW'(1);
        SOLTA:
          if (tempo_q != TW'(RELEASE_CYCLES - 1)) tempo_d = tempo_q + TW'(1);
          else if (ultimo) begin
            estado_d = OBSERVA;
            limpa = 1'b1;
            tempo_d = '0;
            ocioso_d = '0;
          end else begin
            estado_d = PRESSIONA;
            avanca = 1'b1;
            botoes_d = dado_tx;
            tempo_d = '0;
          end
        FIM: estado_d = FIM;
        default: estado_d = INICIAL;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      tempo_q <= '0;
      ocioso_q <= '0;
      botoes_q <= '0;
      erro_q <= 1'b0;
      jogando_q <= 1'b0;
      leds_ant_q <= '0;
    end else begin
      estado_q <= estado_d;
      tempo_q <= tempo_d;
      ocioso_q <= ocioso_d;
      botoes_q <= botoes_d;
      erro_q <= erro_d;
      jogando_q <= (estado_d == PRESSIONA) || (estado_d == SOLTA);
      leds_ant_q <= leds;
    end
  end
  assign botoes = botoes_q;
  assign jogando = jogando_q;
  assign capturados = contagem;
  assign erro_captura = erro_q;
  assign db_estado = estado_q;
endmodule

// File: tb/tb_jogador_automatico.sv
// tb_jogador_automatico: random LED sequences fed to the player, replayed presses checked by a scoreboard
module tb_jogador_automatico;
  localparam int DEPTH = 16;
  localparam int PRESS = 8;
  localparam int RELEASE = 8;
  localparam int IDLE = 64;
  logic clock = 1'b0;
  logic reset, habilita, pronto;
  logic [3:0] leds;
  logic [3:0] botoes, db_estado;
  logic jogando, erro_captura;
  logic [4:0] capturados;
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];
  bit sem_largura = 1'b0;
  bit erro_exp = 1'b0;
  always #5 clock = ~clock;
  jogador_automatico #(.DEPTH(DEPTH), .PRESS_CYCLES(PRESS), .RELEASE_CYCLES(RELEASE), .IDLE_CYCLES(IDLE)) dut (
    .clock(clock),
    .reset(reset),
    .habilita(habilita),
    .leds(leds),
    .pronto(pronto),
`ifdef JOGADOR_INJETA_ERRO_EN
    .injeta_erro(1'b0),
`endif
    .botoes(botoes),
    .jogando(jogando),
    .capturados(capturados),
    .erro_captura(erro_captura),
    .db_estado(db_estado)
  );
  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, got, expv, $time);
    end
  endtask
  // monitor: pops the expected step on each new press and checks press/release widths
  logic [3:0] b_ant = '0;
  int alto = 0;
  int baixo = 0;
  always @(negedge clock) begin
    if (reset) begin
      b_ant = '0;
      alto = 0;
      baixo = 0;
    end else begin
      if (botoes != 4'd0 && b_ant == 4'd0) begin
        if (exp_q.size() == 0) chk("press_extra", {28'd0, botoes}, 32'd0);
        else chk("press_valor", {28'd0, botoes}, {28'd0, exp_q.pop_front()});
        chk("press_onehot_jogando", {31'd0, $onehot(botoes) && jogando}, 32'd1);
        if (baixo != 0) chk("largura_solta", baixo, RELEASE);
        baixo = 0;
      end
      if (botoes == 4'd0 && b_ant != 4'd0 && !sem_largura) chk("largura_press", alto, PRESS);
      alto = (botoes != 4'd0) ? alto + 1 : 0;
      baixo = !jogando ? 0 : (botoes == 4'd0) ? baixo + 1 : baixo;
      b_ant = botoes;
    end
  end
  task automatic gera(input int n, output logic [3:0] s[$]);
    s = {};
    for (int i = 0; i < n; i++) s.push_back(4'b0001 << $urandom_range(3, 0));
  endtask
  // drives the display; on_c/off_c = 0 picks random durations, direto allows back-to-back changes
  task automatic exibe(input logic [3:0] s[$], input int on_c, input int off_c, input bit direto);
    logic [3:0] ant;
    int n;
    n = s.size();
    ant = '0;
    for (int i = 0; i < n; i++) begin
      int on_t, off_t;
      on_t = on_c ? on_c : $urandom_range(12, 1);
      off_t = off_c ? off_c : $urandom_range(20, 1);
      if (i > 0 && !(direto && s[i] != ant && $urandom_range(2, 0) == 0)) begin
        leds = '0;
        repeat (off_t) @(negedge clock);
      end
      leds = s[i];
      if (i < DEPTH) exp_q.push_back(s[i]);
      @(negedge clock);
      if (i == 0) chk("captura_latencia", {27'd0, capturados}, 32'd1);
      repeat (on_t - 1) @(negedge clock);
      ant = s[i];
    end
    if (n > DEPTH) erro_exp = 1'b1;
    chk("capturados", {27'd0, capturados}, (n > DEPTH) ? DEPTH : n);
    chk("erro_captura", {31'd0, erro_captura}, {31'd0, erro_exp});
  endtask
  task automatic inicia_toque;
    leds = '0;
    repeat (IDLE - 1) @(negedge clock);
    chk("antes_toque", {27'd0, jogando, botoes}, 32'd0);
    @(negedge clock);
    chk("inicio_toque", {27'd0, jogando, db_estado}, {27'd0, 1'b1, 4'd3});
  endtask
  task automatic termina_toque(input int n);
    int t;
    t = 0;
    while (jogando && t < n * (PRESS + RELEASE) + 50) begin
      @(negedge clock);
      t++;
    end
    chk("duracao_toque", t, n * (PRESS + RELEASE));
    chk("fim_rodada", {27'd0, capturados, db_estado}, {27'd0, 5'd0, 4'd1});
  endtask
  initial begin
    logic [3:0] s[$];
    int n, t;
    bit algum;
    reset = 1'b1;
    habilita = 1'b0;
    pronto = 1'b0;
    leds = '0;
    repeat (3) @(negedge clock);
    chk("reset_saidas", {18'd0, botoes, jogando, capturados, erro_captura, db_estado}, 32'd0);
    reset = 1'b0;
    habilita = 1'b1;
    @(negedge clock);
    chk("observa", {28'd0, db_estado}, 32'd1);
    s = {4'b0100};
    exibe(s, 20, 0, 1'b0);
    inicia_toque();
    termina_toque(1);
    s = {4'b0001, 4'b1000, 4'b0010};
    exibe(s, 10, 5, 1'b0);
    inicia_toque();
    termina_toque(3);
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(6, 1);
      gera(n, s);
      exibe(s, 0, 0, 1'b1);
      inicia_toque();
      termina_toque(n);
    end
    gera(DEPTH + 1, s);
    exibe(s, 0, 0, 1'b1);
    inicia_toque();
    termina_toque(DEPTH);
    habilita = 1'b0;
    @(negedge clock);
    chk("desabilita_inicial", {28'd0, db_estado}, 32'd0);
    @(negedge clock);
    erro_exp = 1'b0;
    chk("erro_limpo", {31'd0, erro_captura}, 32'd0);
    habilita = 1'b1;
    @(negedge clock);
    leds = 4'b0110;
    @(negedge clock);
    erro_exp = 1'b1;
    chk("leds_invalido", {26'd0, erro_captura, capturados}, {26'd0, 1'b1, 5'd0});
    leds = '0;
    @(negedge clock);
    // abort in the third press cycle
    gera(3, s);
    exibe(s, 0, 0, 1'b1);
    inicia_toque();
    sem_largura = 1'b1;
    repeat (2) @(negedge clock);
    habilita = 1'b0;
    @(negedge clock);
    chk("aborta", {23'd0, botoes, capturados}, 32'd0);
    chk("aborta_estado", {28'd0, db_estado}, 32'd0);
    exp_q.delete();
    erro_exp = 1'b0;
    habilita = 1'b1;
    repeat (2) @(negedge clock);
    sem_largura = 1'b0;
    // game ends during a release
    gera(2, s);
    exibe(s, 0, 0, 1'b1);
    inicia_toque();
    t = 0;
    while (db_estado != 4'd4 && t < 40) begin
      @(negedge clock);
      t++;
    end
    chk("achou_solta", {28'd0, db_estado}, 32'd4);
    pronto = 1'b1;
    @(negedge clock);
    pronto = 1'b0;
    chk("fim", {23'd0, jogando, botoes, db_estado}, {23'd0, 1'b0, 4'd0, 4'd5});
    algum = 1'b0;
    repeat (20) begin
      @(negedge clock);
      algum |= (botoes != 4'd0) || (db_estado != 4'd5);
    end
    chk("fim_mantem", {31'd0, algum}, 32'd0);
    exp_q.delete();
    habilita = 1'b0;
    @(negedge clock);
    chk("fim_sai", {28'd0, db_estado}, 32'd0);
    habilita = 1'b1;
    @(negedge clock);
    // reset while a button is held
    s = {4'b1000};
    exibe(s, 5, 0, 1'b0);
    inicia_toque();
    sem_largura = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    chk("reset_press", {24'd0, botoes, db_estado}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    sem_largura = 1'b0;
    chk("pos_reset_observa", {28'd0, db_estado}, 32'd1);
    chk("fila_vazia", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
